// File: rtl/memprog_carga_pkg.sv
// memprog_carga_pkg
//   Shared definitions for the loadable program memory: loader state
//   encoding, default geometry and the byte-to-word packing factor.
package memprog_carga_pkg;

    localparam int AW_DEF         = 10;
    localparam int DW_DEF         = 16;
    localparam int BYTES_PER_WORD = 2;

    // CHECK and ERROR are only reachable when the checksum build option is on.
    typedef enum logic [2:0] {
        HI,
        LO,
        RUN,
        CHECK,
        ERROR
    } state_e;

endpackage

// File: rtl/memprog_carga_ram_prog.sv
// ram_prog
//   2^AW x DW program store. Synchronous write, asynchronous read, no reset:
//   contents survive reset and are undefined at power-up.
// Ports
//   clk     in   write clock
//   we      in   write enable
//   wa      in   write address
//   wd      in   write data
//   ra      in   read address
//   rd      out  read data (combinational)
module ram_prog
    import memprog_carga_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    assign rd = mem[ra];

endmodule

// File: rtl/memprog_carga.sv
// memprog_carga
//   Loadable program memory. After reset it holds the CPU in reset, packs an
//   incoming byte stream (high byte first) into words at addresses 0,1,2,...
//   then releases the CPU and serves instruction fetches.
//   Build option MEMPROG_CARGA_CHECKSUM_EN: after the program a single check
//   byte must equal the mod-256 sum of all program bytes, else the block
//   parks in ERROR until reset.
// Ports
//   clk          in   clock
//   reset        in   synchronous reset, active low
//   dir          in   fetch address
//   instruccion  out  mem[dir], combinational
//   load_valid   in   load_byte valid
//   load_byte    in   program byte
//   load_last    in   final program byte marker
//   load_ready   out  a byte is accepted this cycle if valid
//   cpu_rst      out  datapath reset, high except while running
//   done         out  program loaded, CPU running
//   err          out  checksum failure (0 without the build option)
//   word_count   out  words written since reset
module memprog_carga
    import memprog_carga_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] dir,
    output logic [DW-1:0] instruccion,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    input  logic          load_last,
    output logic          load_ready,
    output logic          cpu_rst,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count
);

`ifdef MEMPROG_CARGA_CHECKSUM_EN
    localparam state_e EXIT_ST = CHECK;
`else
    localparam state_e EXIT_ST = RUN;
`endif

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW:0]     wcnt_q, wcnt_d;
    logic [7:0]      hi_q, hi_d;
    logic            we;
    logic [DW-1:0]   wd;
    logic            accept;
    logic            at_top;
`ifdef MEMPROG_CARGA_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    assign accept = load_valid & load_ready;
    assign at_top = (addr_q == {AW{1'b1}});

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        hi_d    = hi_q;
        we      = 1'b0;
        wd      = DW'({hi_q, load_byte});
`ifdef MEMPROG_CARGA_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            HI: begin
                if (accept) begin
                    if (load_last) begin
                        // Odd-length program: pad the lone byte with a zero low byte.
                        we      = 1'b1;
                        wd      = DW'({load_byte, 8'h00});
                        state_d = EXIT_ST;
                    end else begin
                        hi_d    = load_byte;
                        state_d = LO;
                    end
                end
            end
            LO: begin
                if (accept) begin
                    we      = 1'b1;
                    // Filling the last address ends the load even without load_last.
                    state_d = (load_last || at_top) ? EXIT_ST : HI;
                end
            end
`ifdef MEMPROG_CARGA_CHECKSUM_EN
            CHECK: begin
                if (accept) state_d = (load_byte == sum_q) ? RUN : ERROR;
            end
`endif
            default: ;
        endcase

`ifdef MEMPROG_CARGA_CHECKSUM_EN
        if (accept && (state_q == HI || state_q == LO)) sum_d = sum_q + load_byte;
`endif

        if (we) begin
            wcnt_d = wcnt_q + 1'b1;
            // Saturate rather than wrap; the FSM leaves loading on this write anyway.
            if (!at_top) addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= HI;
            addr_q  <= '0;
            wcnt_q  <= '0;
            hi_q    <= '0;
`ifdef MEMPROG_CARGA_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            hi_q    <= hi_d;
`ifdef MEMPROG_CARGA_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign load_ready = (state_q == HI) || (state_q == LO) || (state_q == CHECK);
    assign cpu_rst    = (state_q != RUN);
    assign done       = (state_q == RUN);
    assign word_count = wcnt_q;
`ifdef MEMPROG_CARGA_CHECKSUM_EN
    assign err        = (state_q == ERROR);
`else
    assign err        = 1'b0;
`endif

    ram_prog #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk (clk),
        .we  (we),
        .wa  (addr_q),
        .wd  (wd),
        .ra  (dir),
        .rd  (instruccion)
    );

endmodule

// File: tb/tb_memprog_carga.sv
module tb_memprog_carga;
    import memprog_carga_pkg::*;

    localparam int AW    = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] dir = '0;
    logic [DW-1:0] instruccion;
    logic          load_valid = 1'b0;
    logic [7:0]    load_byte = 8'h00;
    logic          load_last = 1'b0;
    logic          load_ready, cpu_rst, done, err;
    logic [AW:0]   word_count;

    always #5 clk = ~clk;

    memprog_carga #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .dir         (dir),
        .instruccion (instruccion),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_rst     (cpu_rst),
        .done        (done),
        .err         (err),
        .word_count  (word_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: expected memory image (with known-written flags), word count,
    // and final condition (0 loading, 1 running, 2 checksum error).
    logic [15:0] exp_mem [DEPTH];
    bit          exp_ok  [DEPTH];
    int          exp_wc;
    logic [7:0]  prog_q [$];
    int          last_idx;
    int          n_use;
    bit          exited;
    logic [7:0]  sum;
    int          fin;
`ifdef MEMPROG_CARGA_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic put(input logic [7:0] b, input logic last);
        @(negedge clk);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
    endtask

    task automatic quiet();
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_byte  = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_ready", load_ready, 1);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wc", word_count, 0);
    endtask

    // Apply the packing rules to prog_q: pairs of bytes form words, a last
    // byte in high position is zero padded, filling DEPTH words ends the load.
    task automatic model();
        int w = 0;
        int i = 0;
        sum = 8'h00; exited = 0; n_use = 0;
        while (i < prog_q.size() && !exited) begin
            sum = sum + prog_q[i];
            n_use = i + 1;
            if (i == last_idx) begin
                exp_mem[w] = {prog_q[i], 8'h00}; exp_ok[w] = 1; w++;
                exited = 1;
            end else if (i + 1 < prog_q.size()) begin
                sum = sum + prog_q[i+1];
                n_use = i + 2;
                exp_mem[w] = {prog_q[i], prog_q[i+1]}; exp_ok[w] = 1; w++;
                exited = (i + 1 == last_idx) || (w == DEPTH);
            end
            i += 2;
        end
        exp_wc = w;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_wc"}, word_count, exp_wc);
        chk({tag, "_ready"}, load_ready, (fin == 0));
        chk({tag, "_cpu_rst"}, cpu_rst, (fin != 1));
        chk({tag, "_done"}, done, (fin == 1));
        chk({tag, "_err"}, err, (fin == 2));
        for (int k = 0; k < DEPTH; k++) begin
            if (exp_ok[k]) begin
                dir = AW'(k);
                #1;
                chk({tag, "_mem"}, instruccion, exp_mem[k]);
            end
        end
    endtask

    // gap < 0: random 0..2 idle cycles between bytes. ck: 0 good check byte,
    // 1 bad, 2 random (only used in the checksum build).
    task automatic run_load(input string tag, input int gap, input int ck);
        int wc_run = 0;
        int g;
        bit good;
        model();
        for (int i = 0; i < n_use; i++) begin
            put(prog_q[i], (i == last_idx));
            if ((i % 2 == 1) || (i == last_idx)) wc_run++;
            if (i < n_use - 1) begin
                g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
                repeat (g) begin
                    quiet();
                    chk({tag, "_gap_wc"}, word_count, wc_run);
                    chk({tag, "_gap_done"}, done, 0);
                end
            end
        end
        quiet();
        // Edge that accepted the final byte releases the CPU (no checksum).
        chk({tag, "_edge_done"}, done, exited && !CK);
        chk({tag, "_edge_cpu_rst"}, cpu_rst, !(exited && !CK));
        fin = exited ? 1 : 0;
        if (CK && exited) begin
            chk({tag, "_ck_ready"}, load_ready, 1);
            good = (ck == 0) || (ck == 2 && $urandom_range(1, 0) == 1);
            put(good ? sum : (sum ^ 8'($urandom_range(255, 1))), 1'($urandom));
            quiet();
            fin = good ? 1 : 2;
        end
        check_state(tag);
        if (fin != 0) begin
            put(8'hFF, 1'($urandom));
            chk({tag, "_junk_ready"}, load_ready, 0);
            quiet();
            quiet();
            check_state({tag, "_junk"});
        end
    endtask

    initial begin
        int len;
        for (int k = 0; k < DEPTH; k++) exp_ok[k] = 0;

        // Basic 2-word program.
        do_reset();
        prog_q = '{8'h12, 8'h34, 8'hAB, 8'hCD}; last_idx = 3;
        run_load("basic", 0, 0);
        dir = 1; #1;
        chk("basic_dir1", instruccion, 16'hABCD);
        chk("basic_wc2", word_count, 2);

        // Same stream with 3 stall cycles between bytes.
        do_reset();
        run_load("stall", 3, 0);

        // Odd length, last byte in high position.
        do_reset();
        prog_q = '{8'h01, 8'h02, 8'h03}; last_idx = 2;
        run_load("odd", 0, 0);
        dir = 1; #1;
        chk("odd_dir1", instruccion, 16'h0300);

        // Reset in mid-load after 5 bytes, then reload.
        do_reset();
        prog_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5}; last_idx = -1;
        run_load("partial", 0, 0);
        do_reset();
        prog_q = '{8'h12, 8'h34, 8'hAB, 8'hCD}; last_idx = 3;
        run_load("reload", 1, 0);

        // Full memory without load_last; the following byte is refused.
        do_reset();
        prog_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        last_idx = -1;
        run_load("full", 0, 0);

        if (CK) begin
            do_reset();
            prog_q = '{8'h10, 8'h20}; last_idx = 1;
            run_load("ck_good", 0, 0);
            do_reset();
            run_load("ck_bad", 0, 1);
        end

        // Randomized programs.
        for (int t = 0; t < 30; t++) begin
            do_reset();
            len = int'($urandom_range(10, 1));
            prog_q = {};
            for (int i = 0; i < len; i++) prog_q.push_back(8'($urandom));
            last_idx = int'($urandom_range(len, 0)) - 1;
            run_load("rand", -1, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
